// File: rtl/rv32i_multiplier_unit_if.sv
// rv32i_multiplier_unit_if: execute-stage multiplier request/response bundle.
interface rv32i_multiplier_unit_if #(parameter int WIDTH = 16);
    logic                 i_multiplier_en;
    logic [WIDTH-1:0]     i_multiplier_operand_one;
    logic [WIDTH-1:0]     i_multiplier_operand_two;
    logic                 o_multiplier_valid;
    logic [2*WIDTH-1:0]   o_multiplier_result;
    logic                 o_multiplier_busy;
    modport slave (
        input  i_multiplier_en, i_multiplier_operand_one, i_multiplier_operand_two,
        output o_multiplier_valid, o_multiplier_result, o_multiplier_busy
    );
    modport master (
        output i_multiplier_en, i_multiplier_operand_one, i_multiplier_operand_two,
        input  o_multiplier_valid, o_multiplier_result, o_multiplier_busy
    );
endinterface

// File: rtl/rv32i_multiplier_unit.sv
// rv32i_multiplier_unit: iterative shift-add unsigned multiplier, RADIX_BITS multiplier bits per cycle.
module rv32i_multiplier_unit #(
    parameter int WIDTH      = 16,
    parameter int RADIX_BITS = 2
) (
    input logic                    i_clk,
    input logic                    i_rst,
    rv32i_multiplier_unit_if.slave bus
);
    localparam int W2 = 2 * WIDTH;
    localparam int N  = WIDTH / RADIX_BITS;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_COMP = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    if ((WIDTH % RADIX_BITS) != 0 || !(RADIX_BITS == 1 || RADIX_BITS == 2 || RADIX_BITS == 4))
        $error("rv32i_multiplier_unit: illegal WIDTH/RADIX_BITS combination");

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [W2-1:0]    r_acc;
    logic [W2-1:0]    r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_valid;
    logic [W2-1:0]    w_pp;
    logic [W2-1:0]    w_sum;

    assign w_pp  = ({{WIDTH{1'b0}}, r_a} * {{(W2-RADIX_BITS){1'b0}}, r_b[RADIX_BITS-1:0]}) << (r_cnt * RADIX_BITS);
    assign w_sum = r_acc + w_pp;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_valid <= 1'b0;
                    if (bus.i_multiplier_en) begin
                        r_a     <= bus.i_multiplier_operand_one;
                        r_b     <= bus.i_multiplier_operand_two;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_COMP;
                    end
                end
                S_COMP: begin
                    if (!bus.i_multiplier_en) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_acc <= w_sum;
                        r_b   <= r_b >> RADIX_BITS;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(N - 1)) begin
                            r_result <= w_sum;
                            r_valid  <= 1'b1;
                            r_state  <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    // return-to-zero: only a sampled en=0 re-arms acceptance
                    r_valid <= 1'b0;
                    if (!bus.i_multiplier_en) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_multiplier_valid  = r_valid;
    assign bus.o_multiplier_result = r_result;
    assign bus.o_multiplier_busy   = (r_state != S_IDLE);
endmodule

// File: tb/tb_rv32i_multiplier_unit.sv
// tb_rv32i_multiplier_unit: directed checks of the iterative multiplier at radix 2, 1 and 4.
module tb_rv32i_multiplier_unit;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic [31:0] last = '0;

    always #5 clk = ~clk;

    rv32i_multiplier_unit_if #(.WIDTH(16)) m2 ();
    rv32i_multiplier_unit_if #(.WIDTH(16)) m1 ();
    rv32i_multiplier_unit_if #(.WIDTH(16)) m4 ();

    rv32i_multiplier_unit #(.WIDTH(16), .RADIX_BITS(2)) d2 (.i_clk(clk), .i_rst(rst), .bus(m2));
    rv32i_multiplier_unit #(.WIDTH(16), .RADIX_BITS(1)) d1 (.i_clk(clk), .i_rst(rst), .bus(m1));
    rv32i_multiplier_unit #(.WIDTH(16), .RADIX_BITS(4)) d4 (.i_clk(clk), .i_rst(rst), .bus(m4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                       input bit scramble, input int hold, input string tag);
        int lat;
        int nv;
        m2.i_multiplier_operand_one = a;
        m2.i_multiplier_operand_two = b;
        m2.i_multiplier_en = 1'b1;
        tick();
        chk({tag, "_busy_acc"}, 64'(m2.o_multiplier_busy), 64'd1);
        chk({tag, "_keep"}, 64'(m2.o_multiplier_result), 64'(last));
        lat = 0;
        while (!m2.o_multiplier_valid && lat < 40) begin
            tick();
            lat++;
            if (scramble && lat == 3) begin
                m2.i_multiplier_operand_one = 16'hAAAA;
                m2.i_multiplier_operand_two = 16'hAAAA;
            end
        end
        chk({tag, "_lat"}, 64'(lat), 64'd8);
        chk({tag, "_res"}, 64'(m2.o_multiplier_result), 64'(exp));
        last = exp;
        nv = 0;
        for (int k = 0; k <= hold; k++) begin
            tick();
            nv += int'(m2.o_multiplier_valid);
        end
        chk({tag, "_pulse"}, 64'(nv), 64'd0);
        chk({tag, "_busy_done"}, 64'(m2.o_multiplier_busy), 64'd1);
        m2.i_multiplier_en = 1'b0;
        tick();
        chk({tag, "_idle"}, 64'(m2.o_multiplier_busy), 64'd0);
        chk({tag, "_res_hold"}, 64'(m2.o_multiplier_result), 64'(exp));
    endtask

    initial begin
        int lat1;
        int lat4;
        int nv;
        rst = 1'b1;
        m2.i_multiplier_en = 1'b0; m2.i_multiplier_operand_one = '0; m2.i_multiplier_operand_two = '0;
        m1.i_multiplier_en = 1'b0; m1.i_multiplier_operand_one = '0; m1.i_multiplier_operand_two = '0;
        m4.i_multiplier_en = 1'b0; m4.i_multiplier_operand_one = '0; m4.i_multiplier_operand_two = '0;
        #3;
        chk("rst_valid", 64'(m2.o_multiplier_valid), 64'd0);
        chk("rst_result", 64'(m2.o_multiplier_result), 64'd0);
        chk("rst_busy", 64'(m2.o_multiplier_busy), 64'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        // 1-4: full products, operand scramble, zero operand, long en hold
        run(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 0, "t1");
        run(16'h1234, 16'h0010, 32'h00012340, 1'b1, 0, "t2");
        run(16'h0000, 16'hBEEF, 32'h00000000, 1'b0, 0, "t3");
        run(16'h0003, 16'h0005, 32'h0000000F, 1'b0, 20, "t4");
        // 5: abort during compute
        m2.i_multiplier_operand_one = 16'h7777;
        m2.i_multiplier_operand_two = 16'h7777;
        m2.i_multiplier_en = 1'b1;
        tick();
        tick();
        tick();
        tick();
        m2.i_multiplier_en = 1'b0;
        tick();
        chk("t5_abort_busy", 64'(m2.o_multiplier_busy), 64'd0);
        chk("t5_abort_valid", 64'(m2.o_multiplier_valid), 64'd0);
        nv = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            nv += int'(m2.o_multiplier_valid);
        end
        chk("t5_no_valid", 64'(nv), 64'd0);
        chk("t5_res_kept", 64'(m2.o_multiplier_result), 64'h0000000F);
        run(16'h0100, 16'h0100, 32'h00010000, 1'b0, 0, "t5");
        // 6: asynchronous reset mid-compute
        m2.i_multiplier_operand_one = 16'hFFFF;
        m2.i_multiplier_operand_two = 16'hFFFF;
        m2.i_multiplier_en = 1'b1;
        tick();
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_valid", 64'(m2.o_multiplier_valid), 64'd0);
        chk("t6_rst_result", 64'(m2.o_multiplier_result), 64'd0);
        chk("t6_rst_busy", 64'(m2.o_multiplier_busy), 64'd0);
        m2.i_multiplier_en = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("t6_idle_after", 64'(m2.o_multiplier_busy), 64'd0);
        m1.i_multiplier_operand_one = 16'hFFFF; m1.i_multiplier_operand_two = 16'hFFFF; m1.i_multiplier_en = 1'b1;
        m4.i_multiplier_operand_one = 16'hFFFF; m4.i_multiplier_operand_two = 16'hFFFF; m4.i_multiplier_en = 1'b1;
        tick();
        lat1 = 0;
        lat4 = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (m1.o_multiplier_valid && lat1 == 0) lat1 = k;
            if (m4.o_multiplier_valid && lat4 == 0) lat4 = k;
        end
        chk("t6_r1_lat", 64'(lat1), 64'd16);
        chk("t6_r4_lat", 64'(lat4), 64'd4);
        chk("t6_r1_res", 64'(m1.o_multiplier_result), 64'hFFFE0001);
        chk("t6_r4_res", 64'(m4.o_multiplier_result), 64'hFFFE0001);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
